// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
//   op_e    : operation codes driven on muldiv_unit.op (codes 6 and 7 reserved)
//   state_e : control FSM states
//   cnt_width() : width of the iteration counter for a given operand width
package muldiv_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 32;

  // One extra bit so the counter can hold WIDTH itself.
  function automatic int unsigned cnt_width(int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/muldiv_unit_sgn_abs.sv
// Conditional two's-complement negate.
//   din  : value to condition
//   neg  : 1 = output -din, 0 = pass din through
//   dout : result, same width as din
// Used both for operand absolute values (neg = sign bit) and for
// result sign correction (neg = result-sign flag).
module sgn_abs #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide unit with HI/LO registers.
//   clk, reset : rising-edge clock, synchronous active-low reset
//   start, op  : request and operation (muldiv_pkg::op_e), sampled in IDLE
//   a, b       : rs / rt operands
//   flush      : abort the in-flight operation (also blocks a new request)
//   busy       : high while state != IDLE
//   done       : one-cycle pulse after MULT/DIV results land in HI/LO
//   hi, lo     : HI and LO result registers
// Signed operations run on magnitudes; signs are restored in FIX.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // acc: running partial product (mult) or partial remainder (div)
  // mq : multiplier being shifted out (mult) or dividend/quotient (div)
  // opd: multiplicand (mult) or divisor (div)
  logic [WIDTH-1:0]   acc_q, acc_d, mq_q, mq_d, opd_q, opd_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;  // negate product / quotient
  logic               neg_rem_q, neg_rem_d;  // negate remainder
  logic               divz_q, divz_d;

  op_e                op_in;
  logic               signed_op;
  logic [WIDTH-1:0]   abs_a, abs_b, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0]     sum, shifted;
  logic [WIDTH-1:0]   diff;
  logic               ge;

  assign op_in     = op_e'(op);
  assign signed_op = (op_in == MULT) || (op_in == DIV);

  sgn_abs #(.W(WIDTH))   u_abs_a (.din(a), .neg(signed_op & a[WIDTH-1]), .dout(abs_a));
  sgn_abs #(.W(WIDTH))   u_abs_b (.din(b), .neg(signed_op & b[WIDTH-1]), .dout(abs_b));
  sgn_abs #(.W(2*WIDTH)) u_fix_p (.din({acc_q, mq_q}), .neg(neg_res_q), .dout(prod_fix));
  sgn_abs #(.W(WIDTH))   u_fix_q (.din(mq_q), .neg(neg_res_q), .dout(quo_fix));
  sgn_abs #(.W(WIDTH))   u_fix_r (.din(acc_q), .neg(neg_rem_q), .dout(rem_fix));

  // Multiply step: conditionally add multiplicand, then shift {acc,mq} right.
  assign sum     = {1'b0, acc_q} + {1'b0, (mq_q[0] ? opd_q : '0)};
  // Divide step: shift next dividend bit into the remainder, trial-subtract.
  assign shifted = {acc_q, mq_q[WIDTH-1]};
  assign ge      = shifted >= {1'b0, opd_q};
  // Only taken when ge, so the true difference is < divisor and fits WIDTH bits.
  assign diff    = shifted[WIDTH-1:0] - opd_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    opd_d     = opd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    divz_d    = divz_q;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          case (op_in)
            MULT, MULTU, DIV, DIVU: begin
              state_d   = CALC;
              cnt_d     = '0;
              acc_d     = '0;
              is_div_d  = (op_in == DIV) || (op_in == DIVU);
              neg_res_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_rem_d = signed_op & a[WIDTH-1];
              divz_d    = (b == '0);
              mq_d      = is_div_d ? abs_a : abs_b;
              opd_d     = is_div_d ? abs_b : abs_a;
            end
            MTHI:    hi_d = a;
            MTLO:    lo_d = a;
            default: ;
          endcase
        end
      end

      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (is_div_q) begin
            acc_d = ge ? diff : shifted[WIDTH-1:0];
            mq_d  = {mq_q[WIDTH-2:0], ge};
          end else begin
            acc_d = sum[WIDTH:1];
            mq_d  = {sum[0], mq_q[WIDTH-1:1]};
          end
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
        end
      end

      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = prod_fix;
          end else begin
            // Divide by zero leaves |a| in the remainder; restoring its sign gives hi = a.
            lo_d = divz_q ? '1 : quo_fix;
            hi_d = rem_fix;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: no memories here, so every flop (datapath included) is reset cheaply.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      opd_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      opd_q     <= opd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      divz_q    <= divz_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH = 32).
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are then sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then run until done (bounded).
  // lat = edges from the accepting edge up to and including the one raising done.
  task automatic launch(input op_e o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int bcyc);
    op = o; a = x; b = y; start = 1'b1;
    lat = 0; bcyc = 0;
    do begin
      step();
      start = 1'b0;
      lat++;
      if (busy) bcyc++;
    end while (!done && lat < 100);
  endtask

  task automatic run_check(input string tag, input op_e o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
    int lat, bcyc;
    launch(o, x, y, lat, bcyc);
    check({tag, " latency"}, 64'(lat), 64'd34);
    check({tag, " hi"}, 64'(hi), 64'(ehi));
    check({tag, " lo"}, 64'(lo), 64'(elo));
  endtask

  initial begin
    int  lat, bcyc;
    logic seen_done;

    reset = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (3) step();
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    reset = 1'b1;
    step();

    // MULT -3 * 7 = -21, with exact latency and busy width
    launch(MULT, 32'hFFFF_FFFD, 32'd7, lat, bcyc);
    check("mult latency", 64'(lat), 64'd34);
    check("mult busy cycles", 64'(bcyc), 64'd33);
    check("mult busy at done", 64'(busy), 64'd0);
    check("mult hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult lo", 64'(lo), 64'hFFFF_FFEB);

    // MULTU max*max, then a back-to-back op started in the done cycle
    run_check("multu max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_check("multu b2b", MULTU, 32'd3, 32'd5, 32'd0, 32'd15);

    // Divides: sign rules and boundary cases
    run_check("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_check("div 7/-2", DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_check("divu 100/7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_check("divu by 0", DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    run_check("div -5 by 0", DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_check("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    // MTHI / MTLO: one edge, no busy, no done
    op = MTHI; a = 32'h1234; start = 1'b1;
    step();
    start = 1'b0;
    check("mthi hi", 64'(hi), 64'h1234);
    check("mthi busy", 64'(busy), 64'd0);
    check("mthi done", 64'(done), 64'd0);
    op = MTLO; a = 32'h55; start = 1'b1;
    step();
    start = 1'b0;
    check("mtlo lo", 64'(lo), 64'h55);

    // flush beats a start in IDLE
    op = MTLO; a = 32'h99; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    check("flush idle lo", 64'(lo), 64'h55);
    check("flush idle busy", 64'(busy), 64'd0);

    // Reserved op code is ignored
    op = 3'd6; start = 1'b1;
    step();
    start = 1'b0;
    check("reserved op busy", 64'(busy), 64'd0);

    // Start while busy is ignored (result and latency unaffected)
    op = MULTU; a = 32'd2; b = 32'd3; start = 1'b1;
    step();
    op = MTHI; a = 32'hBEEF; b = 32'd9;
    repeat (5) step();
    op = MULTU; a = 32'd100;
    repeat (5) step();
    start = 1'b0;
    lat = 11;
    while (!done && lat < 100) begin
      step();
      lat++;
    end
    check("busy start latency", 64'(lat), 64'd34);
    check("busy start lo", 64'(lo), 64'd6);
    check("busy start hi", 64'(hi), 64'd0);

    // Restore HI, then flush on CALC cycle 10
    op = MTHI; a = 32'h1234; start = 1'b1;
    step();
    op = MULT; a = 32'd11; b = 32'd13;
    step();
    start = 1'b0;
    check("flush run busy", 64'(busy), 64'd1);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush done", 64'(done), 64'd0);
    seen_done = 1'b0;
    repeat (40) begin
      step();
      if (done) seen_done = 1'b1;
    end
    check("flush no done", 64'(seen_done), 64'd0);
    check("flush hi kept", 64'(hi), 64'h1234);
    check("flush lo kept", 64'(lo), 64'd6);

    // Reset mid-CALC, and start ignored while reset is held
    op = MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    reset = 1'b0;
    step();
    check("rst mid busy", 64'(busy), 64'd0);
    check("rst mid done", 64'(done), 64'd0);
    check("rst mid hi", 64'(hi), 64'd0);
    check("rst mid lo", 64'(lo), 64'd0);
    op = MTHI; a = 32'h5; start = 1'b1;
    step();
    check("rst held mthi", 64'(hi), 64'd0);
    op = MULT;
    step();
    check("rst held busy", 64'(busy), 64'd0);
    start = 1'b0;
    reset = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
